uart_tx_oversampled: RTL and testbench
======================================

Name: uart_tx_oversampled

Overview:
UART transmitter timed by the shared 16x oversample tick (os_tick) instead of a 1x baud tick. Its frame timing therefore matches uart_rx_oversampled exactly, so both ends run from one baud_generator instance. Data arrives from the TX FIFO drain logic through a valid/ready handshake and leaves on tx_line as a standard UART frame: start bit, data bits LSB first, optional parity bit, then stop bits.

Parameters:
DATA_BITS, 8, payload width (5..9)
PARITY_EN, 1, 1 = append parity bit after data
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN = 0)
STOP_BITS, 1, number of stop bits (1 or 2)
OS_RATE, 16, os_tick periods per bit

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-low (block is in reset while rst = 0)
os_tick  input  1  single-cycle oversample strobe from baud_generator
tx_valid  input  1  tx_data is valid
tx_data  input  DATA_BITS  byte to send
tx_ready  output  1  block can accept a byte
tx_line  output  1  serial output, idles high
tx_busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse at end of the last stop bit

Behaviour:
- Reset (rst = 0 at a clk edge): state IDLE, tx_line = 1, tx_ready = 1, tx_busy = 0, tx_done = 0; shift register, os counter and bit counter cleared. Reset mid-frame aborts the frame and returns tx_line high on the next edge, with no partial stop bit.
- States: IDLE -> START -> DATA -> PARITY (skipped if PARITY_EN = 0) -> STOP -> IDLE.
- Acceptance: the byte is taken when tx_valid && tx_ready at a clk edge. tx_data is sampled only then and later changes are ignored. tx_ready = 1 only in IDLE. tx_valid outside IDLE is ignored (no queueing).
- On acceptance: data is latched, parity is computed (XOR of data, inverted if PARITY_ODD), os counter = 0, state = START, tx_busy = 1 and tx_line = 0 from the next edge.
- Bit timing:
  - Each bit is held for exactly OS_RATE os_ticks. The os counter increments only on os_tick. On the tick that reaches OS_RATE-1 the counter wraps to 0 and the bit advances.
  - The first bit period starts counting at the first os_tick after acceptance, so the start bit lasts between OS_RATE and OS_RATE+1 tick intervals.
  - os_tick is ignored in IDLE.
- DATA: LSB first, exactly DATA_BITS bits, tracked by a bit counter.
- STOP: tx_line = 1 for STOP_BITS x OS_RATE ticks.
- End of frame: on the final wrapping os_tick, tx_done pulses high for one cycle, the state returns to IDLE and tx_busy drops. tx_ready is high from the following cycle.
- Back-to-back: tx_valid held high is accepted on the first IDLE cycle. The inter-frame gap is therefore at most one os_tick interval plus one clk.
- No combinational path from any input to tx_line; tx_line is a register.

Test Plan:
- Bench setup: clk = 100 MHz, os_tick every 6 clks, OS_RATE = 16, so 1 bit = 96 clks. PARITY_EN = 1, PARITY_ODD = 0, STOP_BITS = 1.
- Send 0xA5 -> tx_line reads 0, 1,0,1,0,0,1,0,1, parity 0, stop 1. Frame = 11 bits = 1056 clks ±6. Exactly one tx_done pulse. tx_ready is low throughout the frame.
- PARITY_ODD = 1, send 0x3C -> parity bit = 1. Loopback into uart_rx_oversampled (PARITY_EN = 1, matching odd parity) gives rx_data = 0x3C and parity_error = 0.
- Hold tx_valid with 0x11 then 0x22 queued from the TX FIFO -> two frames, gap between stop bit end and next start ≤ 7 clks. The receiver outputs 0x11 then 0x22.
- Change tx_data to 0xFF while busy, and pulse tx_valid mid-frame -> the current frame is unchanged and no second frame is started.
- Assert rst = 0 during data bit 3 of 0xF0 -> tx_line = 1, tx_busy = 0, tx_ready = 1 one edge later, with no tx_done. A new 0x5A sent after release transmits correctly.
- STOP_BITS = 2, send 0x00 -> stop high for 192 clks; frame = 12 bits = 1152 clks.

Source files
------------

// File: rtl/uart_tx_oversampled.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_oversampled : UART transmitter paced by the shared oversample tick
// Revision 1.0
// ----------------------------------------------------------------------------
module uart_tx_oversampled #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int OS_RATE    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 os_tick,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_line,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int              CNT_W       = (OS_RATE > 2) ? $clog2(OS_RATE) : 1;
  localparam logic [CNT_W-1:0] C_OS_LAST  = CNT_W'(OS_RATE - 1);
  localparam logic [3:0]      C_DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      C_STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic            C_ODD       = (PARITY_ODD != 0);
  localparam logic            C_PAR       = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;
  logic                 r_armed;
  logic [CNT_W-1:0]     r_os_cnt;
  logic [3:0]           r_bit_cnt;
  logic                 w_bit_end;

  // r_armed delays counting until the first tick after acceptance, so the
  // start bit spans between OS_RATE and OS_RATE+1 tick intervals.
  assign w_bit_end = os_tick && r_armed && (r_os_cnt == C_OS_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_armed   <= 1'b0;
      r_os_cnt  <= '0;
      r_bit_cnt <= '0;
      tx_line   <= 1'b1;
      tx_ready  <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;

      if (r_state != S_IDLE && os_tick) begin
        if (!r_armed)
          r_armed <= 1'b1;
        else if (r_os_cnt == C_OS_LAST)
          r_os_cnt <= '0;
        else
          r_os_cnt <= r_os_cnt + CNT_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (tx_valid && tx_ready) begin
            r_shift   <= tx_data;
            r_parity  <= (^tx_data) ^ C_ODD;
            r_os_cnt  <= '0;
            r_armed   <= 1'b0;
            r_bit_cnt <= '0;
            tx_line   <= 1'b0;
            tx_busy   <= 1'b1;
            tx_ready  <= 1'b0;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            tx_line   <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= '0;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit_cnt == C_DATA_LAST) begin
              r_bit_cnt <= '0;
              if (C_PAR) begin
                tx_line <= r_parity;
                r_state <= S_PARITY;
              end else begin
                tx_line <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
              tx_line   <= r_shift[0];
              r_shift   <= r_shift >> 1;
            end
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            tx_line   <= 1'b1;
            r_bit_cnt <= '0;
            r_state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            if (r_bit_cnt == C_STOP_LAST) begin
              tx_done  <= 1'b1;
              tx_busy  <= 1'b0;
              tx_ready <= 1'b1;
              r_state  <= S_IDLE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
        end
        default: begin
          tx_line  <= 1'b1;
          tx_busy  <= 1'b0;
          tx_ready <= 1'b1;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_oversampled.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_tx_oversampled : scoreboard bench, frames decoded by a sampling monitor
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_uart_tx_oversampled;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       os_tick = 1'b0;
  logic [2:0] tdiv = 3'd0;
  logic       vld = 1'b0;
  logic [7:0] data = 8'h00;
  logic       sel = 1'b0;
  int         cyc = 0;

  logic ready0, line0, busy0, done0;
  logic ready1, line1, busy1, done1;
  wire  vld0 = vld & ~sel;
  wire  vld1 = vld & sel;
  wire  mon_line  = sel ? line1  : line0;
  wire  mon_ready = sel ? ready1 : ready0;
  wire  mon_busy  = sel ? busy1  : busy0;
  wire  mon_done  = sel ? done1  : done0;

  uart_tx_oversampled #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .OS_RATE(16)) dut0 (
    .clk(clk), .rst(rst), .os_tick(os_tick), .tx_valid(vld0), .tx_data(data),
    .tx_ready(ready0), .tx_line(line0), .tx_busy(busy0), .tx_done(done0));

  uart_tx_oversampled #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2), .OS_RATE(16)) dut1 (
    .clk(clk), .rst(rst), .os_tick(os_tick), .tx_valid(vld1), .tx_data(data),
    .tx_ready(ready1), .tx_line(line1), .tx_busy(busy1), .tx_done(done1));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tdiv == 3'd5) begin
      tdiv    <= 3'd0;
      os_tick <= 1'b1;
    end else begin
      tdiv    <= tdiv + 3'd1;
      os_tick <= 1'b0;
    end
  end

  typedef struct {
    logic [15:0] bits;
    int          n;
  } frame_t;

  frame_t q[$];
  int total = 0;
  int bad = 0;
  int exp_done = 0;
  int dcnt = 0;
  int abort_cnt = 0;
  int done_cyc = 0;
  int last_gap = 0;

  always @(posedge clk) begin
    if (rst === 1'b1 && done0 === 1'b1) dcnt <= dcnt + 1;
    if (rst === 1'b1 && done1 === 1'b1) dcnt <= dcnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference frame: start 0, data LSB first, parity, stop bits.
  function automatic frame_t model(input logic [7:0] d, input bit odd, input int stops);
    frame_t f;
    f.bits = '0;
    f.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) f.bits[1+i] = d[i];
    f.bits[9] = (^d) ^ odd;
    for (int s = 0; s < stops; s++) f.bits[10+s] = 1'b1;
    f.n = 10 + stops;
    return f;
  endfunction

  task automatic send(input logic [7:0] d);
    int w = 0;
    @(negedge clk);
    vld  = 1'b1;
    data = d;
    while (mon_ready !== 1'b1 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) chk("send_timeout", 1, 0);
    q.push_back(model(d, sel, sel ? 2 : 1));
    exp_done++;
    @(posedge clk);
  endtask

  task automatic disturb();
    repeat ($urandom_range(100, 600)) @(negedge clk);
    if (mon_ready === 1'b0) begin
      vld  = 1'b1;
      data = 8'hFF;
      @(negedge clk);
      vld = 1'b0;
    end
  endtask

  task automatic drain();
    int w = 0;
    while ((q.size() != 0 || mon_busy !== 1'b0) && w < 4000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 4000) chk("drain_timeout", 1, 0);
    repeat (3) @(negedge clk);
  endtask

  // Monitor: decodes each frame by mid-bit sampling and checks it against the queue.
  initial begin : monitor
    frame_t      e;
    logic [15:0] got;
    int          m, lastm;
    bit          ab, rdy, dn;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && mon_line === 1'b0) begin
        last_gap = cyc - done_cyc;
        if (q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
          for (int i = 0; i < 2000 && mon_busy === 1'b1; i++) @(negedge clk);
        end else begin
          e = q.pop_front();
          got = '0; ab = 0; rdy = 0; dn = 0; m = 0;
          lastm = 51 + 96 * (e.n - 1);
          while (m < lastm + 300 && !dn && !ab) begin
            @(negedge clk);
            m++;
            if (rst !== 1'b1) ab = 1;
            else begin
              if (m <= lastm && mon_ready !== 1'b0) rdy = 1;
              if (m <= lastm && (m % 96) == 51) got[m/96] = mon_line;
              if (mon_done === 1'b1) dn = 1;
            end
          end
          if (ab) begin
            abort_cnt++;
            while (rst !== 1'b1) @(negedge clk);
          end else begin
            chk("frame_bits", 32'(got), 32'(e.bits));
            chk("ready_low_in_frame", 32'(rdy), 0);
            chk("frame_len", 32'(m >= 96 * e.n + 1 && m <= 96 * e.n + 6), 1);
            done_cyc = cyc;
          end
        end
      end
    end
  end

  initial begin : stim
    repeat (5) @(negedge clk);
    chk("rst_line0", 32'(line0), 1);
    chk("rst_ready0", 32'(ready0), 1);
    chk("rst_busy0", 32'(busy0), 0);
    chk("rst_done0", 32'(done0), 0);
    chk("rst_line1", 32'(line1), 1);
    chk("rst_ready1", 32'(ready1), 1);
    chk("rst_busy1", 32'(busy1), 0);
    chk("rst_done1", 32'(done1), 0);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    // Even parity, one stop bit: directed frame with a mid-frame disturbance.
    sel = 1'b0;
    send(8'hA5);
    @(negedge clk);
    vld = 1'b0;
    disturb();
    drain();

    // Held valid: two frames back to back.
    send(8'h11);
    send(8'h22);
    @(negedge clk);
    vld = 1'b0;
    drain();
    chk("b2b_gap_le7", 32'(last_gap <= 7 && last_gap >= 1), 1);

    // Reset during data bit 3 aborts the frame.
    send(8'hF0);
    @(negedge clk);
    vld = 1'b0;
    repeat (429) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_line", 32'(line0), 1);
    chk("abort_busy", 32'(busy0), 0);
    chk("abort_ready", 32'(ready0), 1);
    chk("abort_done", 32'(done0), 0);
    exp_done--;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_seen", 32'(abort_cnt), 1);
    send(8'h5A);
    @(negedge clk);
    vld = 1'b0;
    drain();

    for (int i = 0; i < 16; i++) begin
      send(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 2) != 0) begin
        @(negedge clk);
        vld = 1'b0;
        if ($urandom_range(0, 1) == 1) disturb();
        repeat ($urandom_range(0, 200)) @(negedge clk);
      end
    end
    @(negedge clk);
    vld = 1'b0;
    drain();

    // Odd parity, two stop bits.
    sel = 1'b1;
    repeat (5) @(negedge clk);
    send(8'h3C);
    @(negedge clk);
    vld = 1'b0;
    drain();
    send(8'h00);
    @(negedge clk);
    vld = 1'b0;
    drain();
    for (int i = 0; i < 4; i++) begin
      send(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        vld = 1'b0;
        disturb();
      end
    end
    @(negedge clk);
    vld = 1'b0;
    drain();

    repeat (20) @(negedge clk);
    chk("done_count", 32'(dcnt), 32'(exp_done));
    chk("queue_empty", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
